// File: rtl/vga_timing_monitor_if.sv
// VGA output stream as seen by the timing monitor: syncs, blanks and pixel colour.
// The draw pipeline drives the master side and the monitor listens on the slave side.
interface vga_timing_monitor_if;
    logic        hsync_in;
    logic        vsync_in;
    logic        hblnk_in;
    logic        vblnk_in;
    logic [11:0] rgb_in;

    modport master (
        output hsync_in,
        output vsync_in,
        output hblnk_in,
        output vblnk_in,
        output rgb_in
    );

    modport slave (
        input hsync_in,
        input vsync_in,
        input hblnk_in,
        input vblnk_in,
        input rgb_in
    );
endinterface

// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing checker: recovers pixel coordinates from sync/blank edges,
// measures line, frame and sync lengths, locks onto clean timing and samples a probe pixel.
module vga_timing_monitor #(
    parameter int   H_TOTAL    = 1344,
    parameter int   H_SYNC     = 136,
    parameter int   V_TOTAL    = 806,
    parameter int   V_SYNC_CYC = 8064,
    parameter logic SYNC_ACT   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    vga_timing_monitor_if.slave  vga,
    input  logic [10:0]          probe_x,
    input  logic [10:0]          probe_y,
    input  logic                 err_clr,
    output logic [10:0]          hcount_rec,
    output logic [10:0]          vcount_rec,
    output logic                 pixel_valid,
    output logic [11:0]          probe_rgb,
    output logic                 probe_strobe,
    output logic                 locked,
    output logic [15:0]          frame_count,
    output logic [11:0]          line_len,
    output logic [10:0]          frame_lines,
    output logic [3:0]           err
);

    localparam logic [11:0] H_TOTAL_W = 12'(H_TOTAL);
    localparam logic [11:0] H_SYNC_W  = 12'(H_SYNC);
    localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
    localparam logic [15:0] V_SYNC_W  = 16'(V_SYNC_CYC);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t state, state_next;

    logic        hs_q, vs_q, hb_q, vb_q;
    logic [11:0] hc, hc_next, line_meas;
    logic        as_seen;
    logic [11:0] hs_width, hs_width_next;
    logic [15:0] vs_width, vs_width_next;
    logic        v0, v0_next;
    logic [10:0] vc, vc_next;
    logic [10:0] he_count, he_count_next, lines_meas;
    logic        dirty, dirty_next;
    logic        hs_act, vs_act;
    logic        as_ev, he_ev, ve_ev, hs_end, vs_end, vb_fall;
    logic [3:0]  err_ev;
    logic        pv_next, probe_hit;

    // Sync levels are normalised to "active" so the stored history resets to inactive.
    assign hs_act  = (vga.hsync_in == SYNC_ACT);
    assign vs_act  = (vga.vsync_in == SYNC_ACT);
    assign as_ev   = hb_q & ~vga.hblnk_in;
    assign he_ev   = hs_act & ~hs_q;
    assign ve_ev   = vs_act & ~vs_q;
    assign hs_end  = ~hs_act & hs_q;
    assign vs_end  = ~vs_act & vs_q;
    assign vb_fall = vb_q & ~vga.vblnk_in;

    assign hcount_rec = hc[10:0];
    assign vcount_rec = vc;

    always_comb begin
        line_meas     = (hc == '1) ? hc : hc + 12'd1;
        hc_next       = as_ev ? 12'd0 : line_meas;
        hs_width_next = hs_width;
        if (he_ev) begin
            hs_width_next = 12'd1;
        end else if (hs_act && hs_width != '1) begin
            hs_width_next = hs_width + 12'd1;
        end
        vs_width_next = vs_width;
        if (ve_ev) begin
            vs_width_next = 16'd1;
        end else if (vs_act && vs_width != '1) begin
            vs_width_next = vs_width + 16'd1;
        end
        // A blank falling edge in the same cycle as AS still counts as the first row.
        v0_next = as_ev ? 1'b0 : (vb_fall | v0);
        vc_next = vc;
        if (as_ev) begin
            if (v0 || vb_fall) begin
                vc_next = 11'd0;
            end else if (vc != '1) begin
                vc_next = vc + 11'd1;
            end
        end
        lines_meas    = (he_ev && he_count != '1) ? he_count + 11'd1 : he_count;
        he_count_next = ve_ev ? 11'd0 : lines_meas;
        err_ev[0] = as_ev & as_seen & (line_meas != H_TOTAL_W);
        err_ev[1] = hs_end & (hs_width != H_SYNC_W);
        err_ev[2] = ve_ev & (state != SEARCH) & (lines_meas != V_TOTAL_W);
        err_ev[3] = vs_end & (vs_width != V_SYNC_W);
    end

    // Lock requires one whole VE-to-VE frame with no error event anywhere inside it.
    always_comb begin
        state_next = state;
        dirty_next = ve_ev ? 1'b0 : (dirty | (|err_ev));
        unique case (state)
            SEARCH: begin
                if (ve_ev) state_next = MEASURE;
            end
            MEASURE: begin
                if (ve_ev && !dirty && !(|err_ev)) state_next = LOCKED;
            end
            LOCKED: begin
                if (|err_ev) state_next = MEASURE;
            end
            default: state_next = SEARCH;
        endcase
        pv_next   = (state_next == LOCKED) & ~vga.hblnk_in & ~vga.vblnk_in;
        probe_hit = pv_next & (hc_next == {1'b0, probe_x}) & (vc_next == probe_y);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SEARCH;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            hb_q         <= 1'b0;
            vb_q         <= 1'b0;
            hc           <= '0;
            as_seen      <= 1'b0;
            hs_width     <= '0;
            vs_width     <= '0;
            v0           <= 1'b0;
            vc           <= '0;
            he_count     <= '0;
            dirty        <= 1'b0;
            pixel_valid  <= 1'b0;
            probe_rgb    <= '0;
            probe_strobe <= 1'b0;
            locked       <= 1'b0;
            frame_count  <= '0;
            line_len     <= '0;
            frame_lines  <= '0;
            err          <= '0;
        end else begin
            state        <= state_next;
            hs_q         <= hs_act;
            vs_q         <= vs_act;
            hb_q         <= vga.hblnk_in;
            vb_q         <= vga.vblnk_in;
            hc           <= hc_next;
            as_seen      <= as_seen | as_ev;
            hs_width     <= hs_width_next;
            vs_width     <= vs_width_next;
            v0           <= v0_next;
            vc           <= vc_next;
            he_count     <= he_count_next;
            dirty        <= dirty_next;
            pixel_valid  <= pv_next;
            probe_strobe <= probe_hit;
            locked       <= (state_next == LOCKED);
            err          <= err_ev | (err_clr ? 4'd0 : err);
            if (probe_hit) probe_rgb <= vga.rgb_in;
            if (as_ev) line_len <= line_meas;
            if (ve_ev) frame_lines <= lines_meas;
            if (ve_ev && state == LOCKED) frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor using a scaled-down VGA raster (32x26 totals)
// with injected line, hsync, frame-length and vsync faults plus a mid-frame reset.
module tb_vga_timing_monitor;

    localparam int HT  = 32;
    localparam int HA  = 20;
    localparam int HSS = 22;
    localparam int HSW = 4;
    localparam int VT  = 26;
    localparam int VA  = 16;
    localparam int VSS = 18;
    localparam int VSL = 2;
    localparam int VSC = HT * VSL;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] probe_x, probe_y;
    logic        err_clr;
    logic [10:0] hcount_rec, vcount_rec;
    logic        pixel_valid;
    logic [11:0] probe_rgb;
    logic        probe_strobe;
    logic        locked;
    logic [15:0] frame_count;
    logic [11:0] line_len;
    logic [10:0] frame_lines;
    logic [3:0]  err;

    vga_timing_monitor_if vga();

    vga_timing_monitor #(
        .H_TOTAL    (HT),
        .H_SYNC     (HSW),
        .V_TOTAL    (VT),
        .V_SYNC_CYC (VSC),
        .SYNC_ACT   (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .vga          (vga),
        .probe_x      (probe_x),
        .probe_y      (probe_y),
        .err_clr      (err_clr),
        .hcount_rec   (hcount_rec),
        .vcount_rec   (vcount_rec),
        .pixel_valid  (pixel_valid),
        .probe_rgb    (probe_rgb),
        .probe_strobe (probe_strobe),
        .locked       (locked),
        .frame_count  (frame_count),
        .line_len     (line_len),
        .frame_lines  (frame_lines),
        .err          (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int watchV, watchH;
    int clrV = -1, clrH = -1;
    int rstV = -1, rstH = -1;

    logic        wPre, wLocked, wPv, wStrobe, lastLocked;
    logic [3:0]  wErr;
    logic [15:0] wFc;
    logic [11:0] wLineLen, wRgb;
    logic [10:0] wFl, wHc, wVc;
    int          strobeCnt, pvCnt;
    logic [10:0] strobeH, strobeV;
    logic [11:0] strobeRgb;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One frame of raster; outputs are sampled 1 time unit after the edge that took each pixel.
    task automatic applyStimulus(input int nLines, input int longLine, input int shortHsLine, input bit shortVs);
        int hLen;
        int hsW;
        strobeCnt = 0;
        pvCnt     = 0;
        for (int v = 0; v < nLines; v++) begin
            hLen = (v == longLine) ? HT + 1 : HT;
            hsW  = (v == shortHsLine) ? HSW - 1 : HSW;
            for (int h = 0; h < hLen; h++) begin
                vga.hblnk_in = (h >= HA);
                vga.vblnk_in = (v >= VA);
                vga.hsync_in = (h >= HSS) && (h < HSS + hsW);
                vga.vsync_in = (v >= VSS) && (v < VSS + VSL) && !(shortVs && v == VSS + VSL - 1 && h == hLen - 1);
                if (h < HA && v < VA)
                    vga.rgb_in = (h == 5 && v == 10) ? 12'h01c : {h[5:0], v[5:0]};
                else
                    vga.rgb_in = 12'h000;
                err_clr = (v == clrV && h == clrH);
                rst     = (v == rstV && h == rstH);
                @(posedge clk);
                #1;
                if (probe_strobe) begin
                    strobeCnt++;
                    strobeH   = hcount_rec;
                    strobeV   = vcount_rec;
                    strobeRgb = probe_rgb;
                end
                if (pixel_valid) pvCnt++;
                if (v == watchV && h == watchH) begin
                    wPre     = lastLocked;
                    wLocked  = locked;
                    wErr     = err;
                    wFc      = frame_count;
                    wLineLen = line_len;
                    wFl      = frame_lines;
                    wHc      = hcount_rec;
                    wVc      = vcount_rec;
                    wPv      = pixel_valid;
                    wStrobe  = probe_strobe;
                    wRgb     = probe_rgb;
                end
                lastLocked = locked;
            end
        end
        err_clr = 1'b0;
        rst     = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        err_clr      = 1'b0;
        probe_x      = 11'd5;
        probe_y      = 11'd10;
        vga.hsync_in = 1'b0;
        vga.vsync_in = 1'b0;
        vga.hblnk_in = 1'b1;
        vga.vblnk_in = 1'b1;
        vga.rgb_in   = 12'h000;
        lastLocked   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_locked", locked, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_fcount", frame_count, 0);
        checkOutput("rst_line_len", line_len, 0);
        checkOutput("rst_frame_lines", frame_lines, 0);
        checkOutput("rst_hcount", hcount_rec, 0);
        checkOutput("rst_vcount", vcount_rec, 0);
        checkOutput("rst_pv", pixel_valid, 0);
        checkOutput("rst_strobe", probe_strobe, 0);
        checkOutput("rst_probe_rgb", probe_rgb, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        watchV = VSS; watchH = 0;
        applyStimulus(VT, -1, -1, 1'b0);
        checkOutput("a_locked_ve1", wLocked, 0);
        checkOutput("a_fcount", wFc, 0);

        applyStimulus(VT, -1, -1, 1'b0);
        checkOutput("b_locked_before_ve2", wPre, 0);
        checkOutput("b_locked_after_ve2", wLocked, 1);
        checkOutput("b_frame_lines", wFl, VT);
        checkOutput("b_line_len", wLineLen, HT);
        checkOutput("b_err", wErr, 0);
        checkOutput("b_strobes", strobeCnt, 0);

        applyStimulus(VT, -1, -1, 1'b0);
        checkOutput("c_fcount", wFc, 1);
        checkOutput("c_hcount_ve", wHc, 0);
        checkOutput("c_vcount_ve", wVc, VSS);
        checkOutput("c_strobes", strobeCnt, 1);
        checkOutput("c_strobe_h", strobeH, 5);
        checkOutput("c_strobe_v", strobeV, 10);
        checkOutput("c_probe_rgb", strobeRgb, 12'h01c);
        checkOutput("c_pv_count", pvCnt, HA * VA);

        watchV = 4; watchH = 0;
        applyStimulus(VT, 3, -1, 1'b0);
        checkOutput("d_err", wErr, 4'b0001);
        checkOutput("d_locked_before", wPre, 1);
        checkOutput("d_locked_after", wLocked, 0);
        checkOutput("d_line_len", wLineLen, HT + 1);
        checkOutput("d_end_locked", locked, 0);

        watchV = VSS; watchH = 0;
        applyStimulus(VT, -1, -1, 1'b0);
        checkOutput("e_locked_before", wPre, 0);
        checkOutput("e_relocked", wLocked, 1);
        checkOutput("e_err_sticky", wErr, 4'b0001);
        checkOutput("e_fcount", wFc, 1);

        watchV = 5; watchH = HSS + HSW - 1;
        clrV = 8; clrH = 0;
        applyStimulus(VT, -1, 5, 1'b0);
        clrV = -1;
        checkOutput("f_err", wErr, 4'b0011);
        checkOutput("f_locked_before", wPre, 1);
        checkOutput("f_locked_after", wLocked, 0);
        checkOutput("f_end_err_cleared", err, 0);

        watchV = VSS; watchH = 0;
        applyStimulus(VT, -1, -1, 1'b0);
        checkOutput("g_locked_before", wPre, 0);
        checkOutput("g_relocked", wLocked, 1);

        applyStimulus(VT - 1, -1, -1, 1'b0);
        checkOutput("h_locked", wLocked, 1);
        checkOutput("h_fcount", wFc, 2);

        applyStimulus(VT, -1, -1, 1'b1);
        checkOutput("i_frame_lines", wFl, VT - 1);
        checkOutput("i_err_ve", wErr, 4'b0100);
        checkOutput("i_locked_before", wPre, 1);
        checkOutput("i_locked_after", wLocked, 0);
        checkOutput("i_end_err", err, 4'b1100);

        watchV = 8; watchH = 5;
        rstV = 8; rstH = 5;
        applyStimulus(VT, -1, -1, 1'b0);
        rstV = -1;
        checkOutput("j_locked", wLocked, 0);
        checkOutput("j_err", wErr, 0);
        checkOutput("j_fcount", wFc, 0);
        checkOutput("j_line_len", wLineLen, 0);
        checkOutput("j_frame_lines", wFl, 0);
        checkOutput("j_hcount", wHc, 0);
        checkOutput("j_vcount", wVc, 0);
        checkOutput("j_pv", wPv, 0);
        checkOutput("j_strobe", wStrobe, 0);
        checkOutput("j_probe_rgb", wRgb, 0);
        checkOutput("j_end_locked", locked, 0);

        watchV = VSS; watchH = 0;
        applyStimulus(VT, -1, -1, 1'b0);
        checkOutput("k_locked_before", wPre, 0);
        checkOutput("k_locked_after", wLocked, 1);
        checkOutput("k_fcount", wFc, 0);
        checkOutput("k_frame_lines", wFl, VT);

        applyStimulus(VT, -1, -1, 1'b0);
        checkOutput("l_fcount", wFc, 1);
        checkOutput("l_strobes", strobeCnt, 1);
        checkOutput("l_probe_rgb", strobeRgb, 12'h01c);

        probe_x = 11'd25;
        applyStimulus(VT, -1, -1, 1'b0);
        checkOutput("m_strobes_outside", strobeCnt, 0);
        checkOutput("m_probe_rgb_held", probe_rgb, 12'h01c);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
